// File: rtl/vga_scandoubler_par.sv
// vga_scandoubler_par: doubles a source video line rate by replaying each buffered line twice,
// with optional scanline dimming on the second replay and regenerated VGA syncs.
module vga_scandoubler_par #(
    parameter int CW          = 3,
    parameter int LAW         = 10,
    parameter int MIN_LINE    = 128,
    parameter int HSYNC_COUNT = 81,
    parameter int VSYNC_COUNT = 2743
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_src,
    input  logic           ce_vga,
    input  logic [1:0]     scan_mode,
    input  logic [CW-1:0]  ri,
    input  logic [CW-1:0]  gi,
    input  logic [CW-1:0]  bi,
    input  logic           hsync_ext_n,
    input  logic           vsync_ext_n,
    output logic [CW-1:0]  ro,
    output logic [CW-1:0]  go,
    output logic [CW-1:0]  bo,
    output logic           hsync,
    output logic           vsync,
    output logic [LAW-1:0] line_len,
    output logic           ovf
);
    localparam int PW = 3 * CW;
    localparam int VW = $clog2(VSYNC_COUNT + 1);

    logic [PW-1:0]  mem [2**(LAW+1)];
    logic [LAW:0]   wr_cnt_q, wr_cnt_d;
    logic           wr_bank_q, wr_bank_d, ovf_q, ovf_d, done_q, done_d;
    logic [LAW-1:0] len_q, len_d, rd_cnt_q, rd_cnt_d;
    logic           rd_bank_q, rd_bank_d, phase_q, phase_d;
    logic           line_end, wr_en, wrap;
    logic [PW-1:0]  ram_q;
    logic           ph1_q, hs1_q, hsync_q, vsync_q, vsync_d, vs_ext_q, fall;
    logic [CW-1:0]  ro_q, go_q, bo_q;
    logic [VW-1:0]  vcnt_q, vcnt_d;

    function automatic logic [CW-1:0] dim(input logic [CW-1:0] x, input logic on, input logic [1:0] m);
        return !on ? x : m == 2'd1 ? x >> 1 : m == 2'd2 ? x >> 2 : m == 2'd3 ? '0 : x;
    endfunction

    always_comb begin
        line_end  = ce_src && !hsync_ext_n && 32'(wr_cnt_q) >= MIN_LINE;
        wr_en     = ce_src && !line_end && !wr_cnt_q[LAW];
        wr_cnt_d  = line_end ? '0 : wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d = wr_bank_q ^ line_end;
        len_d     = line_end ? LAW'(wr_cnt_q - 1'b1) : len_q;
        ovf_d     = ovf_q | (ce_src && !line_end && wr_cnt_q[LAW]);
        // a fresh line end outranks consumption of the previous one
        done_d    = line_end | (done_q & ~ce_vga);
        wrap      = rd_cnt_q == len_q;
        rd_cnt_d  = !ce_vga ? rd_cnt_q : (done_q || wrap) ? '0 : rd_cnt_q + 1'b1;
        rd_bank_d = (ce_vga && done_q) ? ~wr_bank_q : rd_bank_q;
        phase_d   = !ce_vga ? phase_q : done_q ? 1'b0 : wrap ? 1'b1 : phase_q;
        fall      = vs_ext_q && !vsync_ext_n;
        vcnt_d    = (fall && vcnt_q == '0) ? VW'(VSYNC_COUNT)
                  : (ce_vga && vcnt_q != '0) ? vcnt_q - 1'b1 : vcnt_q;
        vsync_d   = vcnt_d == '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[{wr_bank_q, wr_cnt_q[LAW-1:0]}] <= {ri, gi, bi};
        ram_q <= mem[{rd_bank_q, rd_cnt_q}];
    end

    always_ff @(posedge clk) begin
        vs_ext_q <= vsync_ext_n;
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            len_q     <= '1;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            phase_q   <= 1'b0;
            ph1_q     <= 1'b0;
            hs1_q     <= 1'b1;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            vcnt_q    <= '0;
            ro_q      <= '0;
            go_q      <= '0;
            bo_q      <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            phase_q   <= phase_d;
            ph1_q     <= phase_q;
            hs1_q     <= 32'(rd_cnt_q) >= HSYNC_COUNT;
            hsync_q   <= hs1_q;
            vsync_q   <= vsync_d;
            vcnt_q    <= vcnt_d;
            ro_q      <= dim(ram_q[PW-1:2*CW], ph1_q, scan_mode);
            go_q      <= dim(ram_q[2*CW-1:CW], ph1_q, scan_mode);
            bo_q      <= dim(ram_q[CW-1:0], ph1_q, scan_mode);
        end
    end

    assign ro       = ro_q;
    assign go       = go_q;
    assign bo       = bo_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign line_len = len_q;
    assign ovf      = ovf_q;
endmodule
